// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default FIFO depth, feeder FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } feed_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Circular single-clock FIFO with registered pointers and level, plus sync flush.
// Latency: a write is visible in level/empty one cycle later; rd_data is the head entry, combinational from storage.
// Backpressure: writes while full are dropped and flagged on wr_drop; reads while empty are ignored.
//
// Ports: clk, rst (async, active high), flush (clears pointers/level, wins over a write),
//        wr_en/wr_data (push), rd_en (pop head), rd_data (head entry),
//        full/empty/level (state after the last edge), wr_drop (write refused this cycle).
module uart_sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     wr_drop
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_accept;
    logic              rd_accept;

    // Full is judged on the registered level, so a pop in the same cycle
    // never makes room for a write.
    assign full      = (level == LVL_W'(DEPTH));
    assign empty     = (level == '0);
    assign wr_accept = wr_en && !full && !flush;
    assign rd_accept = rd_en && !empty && !flush;
    assign wr_drop   = wr_en && full && !flush;
    assign rd_data   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_accept, rd_accept})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset; only entries below the level are ever read.
    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and hands them one at a time to the UART transmitter.
// Latency: byte written at edge k gives tx_en/tx_data after edge k+1; 2 feeder cycles per byte plus frame time.
// Backpressure: waits for tx_busy low and tx_done per frame; host writes to a full FIFO are dropped and set overflow.
//
// Ports: clk, rst (async, active high); host side wr_en/wr_data/flush, status full/empty/level/overflow;
//        transmitter side tx_en (1-cycle start), tx_data (held until tx_done), tx_busy, tx_done.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_FIFO_DEPTH,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     tx_en,
    output logic [DATA_W-1:0]        tx_data,
    input  logic                     tx_busy,
    input  logic                     tx_done
);

    feed_state_t       state;
    logic              pop;
    logic              wr_drop;
    logic [DATA_W-1:0] head_data;

    // A flush in the same cycle suppresses the pop so nothing leaves a FIFO
    // that is being cleared.
    assign pop = (state == ST_IDLE) && !empty && !tx_busy && !flush;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head_data),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .wr_drop (wr_drop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx_en    <= 1'b0;
            tx_data  <= '0;
            overflow <= 1'b0;
        end else begin
            if (flush)        overflow <= 1'b0;
            else if (wr_drop) overflow <= 1'b1;

            // tx_en is high only in the cycle the FSM sits in START.
            tx_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        tx_data <= head_data;
                        tx_en   <= 1'b1;
                        state   <= ST_START;
                    end
                end
                ST_START: state <= ST_WAIT;
                // tx_done outside WAIT is ignored; a flush does not abort the frame.
                ST_WAIT:  if (tx_done) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       flush = 1'b0;
    logic       full, empty, overflow, tx_en;
    logic [4:0] level;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done = 1'b0;
    logic       model_busy = 1'b0;
    logic       force_busy = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Transmitter model state
    int         frame_len = 20;
    logic [7:0] sent_q[$];
    int         gap_q[$];
    int         en_cnt = 0, double_en = 0, stable_err = 0, cyc = 0, last_done_cyc = -1;
    bit         frame_active = 1'b0, prev_en = 1'b0;
    int         cnt = 0;
    logic [7:0] cur_byte = 8'h00;

    always #5 clk = ~clk;
    assign tx_busy = force_busy | model_busy;

    uart_tx_feeder #(.DEPTH(DEPTH), .DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .flush    (flush),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .tx_en    (tx_en),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    // Transmitter model: records every started byte, pulses tx_done frame_len
    // cycles after tx_en, and notes protocol violations for later checks.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            frame_active = 1'b0;
            model_busy   = 1'b0;
            tx_done      = 1'b0;
            prev_en      = 1'b0;
        end else begin
            tx_done = 1'b0;
            if (frame_active) begin
                if (tx_data !== cur_byte) stable_err++;
                if (cnt >= frame_len) begin
                    tx_done       = 1'b1;
                    model_busy    = 1'b0;
                    frame_active  = 1'b0;
                    last_done_cyc = cyc;
                end else begin
                    cnt++;
                end
            end
            if (tx_en === 1'b1) begin
                if (prev_en) double_en++;
                sent_q.push_back(tx_data);
                if (last_done_cyc >= 0) gap_q.push_back(cyc - last_done_cyc);
                cur_byte     = tx_data;
                frame_active = 1'b1;
                model_busy   = 1'b1;
                cnt          = 1;
                en_cnt++;
            end
            prev_en = (tx_en === 1'b1);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step(1);
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        wr_en = 1'b0; flush = 1'b0; force_busy = 1'b0; rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);
        sent_q.delete(); gap_q.delete(); last_done_cyc = -1;
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int i;
        for (i = 0; i < budget; i++) begin
            if (empty && !frame_active && !tx_en) break;
            step(1);
        end
        n_checks++;
        if (i == budget) begin
            n_fail++;
            $display("FAIL %s_drain: timeout, level=%0d after %0d cycles", tag, level, budget);
        end
    endtask

    task automatic test_reset();
        wr_en = 1'b0; flush = 1'b0; rst = 1'b1;
        step(2);
        n_checks++; if (tx_en !== 1'b0)   begin n_fail++; $display("FAIL reset_tx_en: got %b want 0", tx_en); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        n_checks++; if (full !== 1'b0)    begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_checks++; if (empty !== 1'b1)   begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_checks++; if (level !== 5'd0)   begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        do_reset();
    endtask

    task automatic test_single();
        frame_len = 20;
        do_reset();
        push(8'hA5);
        n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL single_level_k: got %0d want 1", level); end
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL single_empty_k: got %b want 0", empty); end
        n_checks++; if (tx_en !== 1'b0) begin n_fail++; $display("FAIL single_en_k: got %b want 0", tx_en); end
        step(1);
        n_checks++; if (tx_en !== 1'b1)    begin n_fail++; $display("FAIL single_en_k1: got %b want 1", tx_en); end
        n_checks++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", tx_data); end
        n_checks++; if (level !== 5'd0)    begin n_fail++; $display("FAIL single_level_k1: got %0d want 0", level); end
        n_checks++; if (empty !== 1'b1)    begin n_fail++; $display("FAIL single_empty_k1: got %b want 1", empty); end
        step(1);
        n_checks++; if (tx_en !== 1'b0) begin n_fail++; $display("FAIL single_en_k2: got %b want 0", tx_en); end
        wait_drain(100, "single");
        step(5);
        n_checks++; if (sent_q.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", sent_q.size()); end
        n_checks++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_hold: got %h want a5", tx_data); end
    endtask

    task automatic test_burst();
        frame_len = 20;
        do_reset();
        for (int i = 1; i <= 5; i++) push(8'(i));
        wait_drain(400, "burst");
        n_checks++;
        if (sent_q.size() != 5) begin n_fail++; $display("FAIL burst_count: got %0d want 5", sent_q.size()); end
        for (int i = 0; i < sent_q.size() && i < 5; i++) begin
            n_checks++;
            if (sent_q[i] !== 8'(i + 1)) begin
                n_fail++; $display("FAIL burst_order[%0d]: got %h want %h", i, sent_q[i], 8'(i + 1));
            end
        end
        n_checks++;
        if (gap_q.size() != 4) begin n_fail++; $display("FAIL burst_gaps: got %0d gaps want 4", gap_q.size()); end
        foreach (gap_q[i]) begin
            n_checks++;
            if (gap_q[i] != 2) begin n_fail++; $display("FAIL burst_gap[%0d]: done-to-tx_en %0d cycles want 2", i, gap_q[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] mq[$];
        logic [7:0] b;
        bit         exp_ovf = 1'b0;
        do_reset();
        force_busy = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            push(b);
            if (mq.size() < DEPTH) mq.push_back(b); else exp_ovf = 1'b1;
            n_checks++; if (level !== 5'(mq.size())) begin n_fail++; $display("FAIL ovf_level[%0d]: got %0d want %0d", i, level, mq.size()); end
            n_checks++; if (full !== (mq.size() == DEPTH)) begin n_fail++; $display("FAIL ovf_full[%0d]: got %b want %b", i, full, mq.size() == DEPTH); end
            n_checks++; if (overflow !== exp_ovf) begin n_fail++; $display("FAIL ovf_flag[%0d]: got %b want %b", i, overflow, exp_ovf); end
        end
        n_checks++; if (en_cnt != 0 && sent_q.size() != 0) begin n_fail++; $display("FAIL ovf_busy_hold: got %0d sends want 0", sent_q.size()); end
        frame_len  = 4;
        force_busy = 1'b0;
        wait_drain(600, "ovf");
        n_checks++; if (sent_q.size() != DEPTH) begin n_fail++; $display("FAIL ovf_sent: got %0d want %0d", sent_q.size(), DEPTH); end
        for (int i = 0; i < sent_q.size() && i < DEPTH; i++) begin
            n_checks++;
            if (sent_q[i] !== mq[i]) begin n_fail++; $display("FAIL ovf_data[%0d]: got %h want %h", i, sent_q[i], mq[i]); end
        end
    endtask

    // Runs straight after the overflow test so overflow starts out set.
    task automatic test_flush();
        logic [7:0] w[4];
        frame_len = 20;
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL flush_pre_ovf: got %b want 1", overflow); end
        sent_q.delete();
        foreach (w[i]) begin w[i] = 8'($urandom); push(w[i]); end
        step(2);
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'h3C;
        step(1);
        flush = 1'b0; wr_en = 1'b0;
        n_checks++; if (level !== 5'd0)    begin n_fail++; $display("FAIL flush_level: got %0d want 0", level); end
        n_checks++; if (empty !== 1'b1)    begin n_fail++; $display("FAIL flush_empty: got %b want 1", empty); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL flush_ovf: got %b want 0", overflow); end
        wait_drain(200, "flush");
        step(40);
        n_checks++; if (sent_q.size() != 1) begin n_fail++; $display("FAIL flush_count: got %0d want 1", sent_q.size()); end
        n_checks++; if (sent_q.size() > 0 && sent_q[0] !== w[0]) begin n_fail++; $display("FAIL flush_first: got %h want %h", sent_q[0], w[0]); end
    endtask

    task automatic test_wrap();
        logic [7:0] wq[$];
        logic [7:0] b;
        int         spin;
        frame_len = 3;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            spin = 0;
            while (level >= 5'd15 && spin < 200) begin step(1); spin++; end
            n_checks++;
            if (spin == 200) begin n_fail++; $display("FAIL wrap_throttle[%0d]: level stuck at %0d", i, level); end
            b = 8'($urandom);
            push(b);
            wq.push_back(b);
            step($urandom_range(0, 2));
        end
        wait_drain(800, "wrap");
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf: got %b want 0", overflow); end
        n_checks++; if (sent_q.size() != wq.size()) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", sent_q.size(), wq.size()); end
        for (int i = 0; i < sent_q.size() && i < wq.size(); i++) begin
            n_checks++;
            if (sent_q[i] !== wq[i]) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", i, sent_q[i], wq[i]); end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] b1, b2, b3;
        int         en0;
        frame_len = 20;
        do_reset();
        b1 = 8'($urandom_range(1, 255));
        b2 = 8'($urandom_range(1, 255));
        b3 = 8'($urandom_range(1, 255));
        push(b1);
        push(b2);
        step(5);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (tx_en !== 1'b0)   begin n_fail++; $display("FAIL arst_tx_en: got %b want 0", tx_en); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL arst_tx_data: got %h want 00", tx_data); end
        n_checks++; if (level !== 5'd0)   begin n_fail++; $display("FAIL arst_level: got %0d want 0", level); end
        n_checks++; if (empty !== 1'b1)   begin n_fail++; $display("FAIL arst_empty: got %b want 1", empty); end
        @(posedge clk); #1 rst = 1'b0;
        en0 = en_cnt;
        step(40);
        n_checks++; if (en_cnt != en0) begin n_fail++; $display("FAIL arst_quiet: got %0d tx_en want 0", en_cnt - en0); end
        push(b3);
        step(1);
        n_checks++; if (tx_en !== 1'b1) begin n_fail++; $display("FAIL arst_restart_en: got %b want 1", tx_en); end
        n_checks++; if (tx_data !== b3) begin n_fail++; $display("FAIL arst_restart_data: got %h want %h", tx_data, b3); end
        wait_drain(100, "arst");
    endtask

    task automatic test_protocol();
        n_checks++; if (double_en != 0)  begin n_fail++; $display("FAIL proto_tx_en_width: got %0d double pulses want 0", double_en); end
        n_checks++; if (stable_err != 0) begin n_fail++; $display("FAIL proto_tx_data_hold: got %0d changes want 0", stable_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_flush();
        test_wrap();
        test_async_reset();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Transmit-side buffer that sits directly upstream of the UART top level. It accepts bytes from the host logic at any rate into a circular FIFO and feeds them one at a time to the transmitter through its `tx_en` / `tx_data` / `tx_busy` / `tx_done` handshake. It throttles itself to the serial line rate and reports occupancy and overflow back to the host.

## Interface
Parameters:
- `DEPTH`, default 16: FIFO entries. Power of two, at least 2.
- `DATA_W`, default 8: byte width. Must match the transmitter data width.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `wr_en`, in, 1: host write strobe.
- `wr_data`, in, DATA_W: byte to queue.
- `flush`, in, 1: synchronous FIFO clear. Also clears `overflow`.
- `full`, out, 1: FIFO holds DEPTH entries.
- `empty`, out, 1: FIFO holds 0 entries.
- `level`, out, $clog2(DEPTH)+1: current occupancy.
- `overflow`, out, 1: sticky; a write was dropped.
- `tx_en`, out, 1: one-cycle start pulse to the transmitter.
- `tx_data`, out, DATA_W: byte being sent. Held stable from the `tx_en` cycle until `tx_done`.
- `tx_busy`, in, 1: transmitter busy.
- `tx_done`, in, 1: transmitter frame-complete pulse.

## Operation
- FIFO storage:
  - Write pointer, read pointer and level counter are all registered.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- Write:
  - When `wr_en` is high and `full` is low, the byte is stored and the level increments.
  - When `wr_en` is high and `full` is high, the byte is dropped and `overflow` is set to 1.
  - No write-through when full, even if a pop occurs in the same cycle.
- Pop: occurs only on the IDLE to START transition. The head byte is copied into the `tx_data` register.
- Simultaneous accepted write and pop: level is unchanged and both pointers advance.
- FSM states:
  - IDLE: if `!empty && !tx_busy && !flush`, pop, load `tx_data`, go to START. Otherwise stay.
  - START: `tx_en` = 1 for exactly this cycle. Go to WAIT unconditionally.
  - WAIT: stay until `tx_done` is sampled high, then go to IDLE.
- `tx_en` is a registered decode of START. It is never high for two consecutive cycles.
- `tx_data` is never updated outside the IDLE to START transition.
- `flush`:
  - Resets the pointers and level to 0 and clears `overflow`.
  - Does not abort a byte already in START or WAIT; that byte completes normally.
  - If `flush` and `wr_en` are high in the same cycle, `flush` wins and the write is discarded.
- `tx_done` arriving in IDLE or START is ignored.
- `rst` (any time, including mid-frame): FSM goes to IDLE, pointers and level go to 0. The transmitter is reset by the same `rst`.

## Timing
- Reset values:
  - `tx_en` = 0, `tx_data` = 0.
  - `full` = 0, `empty` = 1, `level` = 0, `overflow` = 0.
  - FSM = IDLE.
- `full`, `empty` and `level` reflect the state after the last clock edge. They are combinational from registers only, with no path from `wr_en`.
- Latency into an idle feeder with `tx_busy` = 0:
  - `wr_en` sampled at edge k: `level` = 1 after edge k.
  - After edge k+1: `tx_en` = 1, `tx_data` valid, `level` = 0.
  - After edge k+2: `tx_en` = 0.
- Back-to-back bytes: with `tx_done` sampled at edge d, the next `tx_en` is high after edge d+1. The minimum gap is one IDLE cycle.
- Throughput is bounded by the transmitter frame time. The feeder adds 2 cycles per byte.

## Structure
- Shared package `uart_pkg`:
  - Feeder state enum (IDLE, START, WAIT).
  - `UART_DATA_W` = 8.
  - Default FIFO depth constant.
- One sub-module, `uart_sync_fifo`:
  - Storage, pointers, level, full/empty and flush logic.
  - Parameterised by DEPTH and DATA_W.
  - Reusable later on the receive side.
- The top of `uart_tx_feeder` holds the FSM, the `tx_data` register and the `overflow` flag.

## Test plan
- Single byte: after reset, write 0xA5 → `tx_en` is one cycle wide 2 cycles later, `tx_data` = 0xA5 held until `tx_done`, `level` returns to 0, `empty` = 1.
- Burst ordering: write 0x01..0x05 on consecutive cycles, with the transmitter model giving `tx_done` 20 cycles after each `tx_en` → exactly 5 `tx_en` pulses in order 0x01..0x05, gaps ≥ 1 cycle after each `tx_done`.
- Full/overflow with DEPTH = 16 and `tx_busy` held high:
  - Write 17 bytes → `full` = 1 after the 16th, the 17th is dropped, `overflow` = 1, `level` = 16.
  - Release `tx_busy` → 16 bytes sent, the 17th is never sent.
- Wrap-around: 40 writes interleaved with drains, keeping the level between 1 and 15 → output sequence equals input sequence, with no loss or duplication across the pointer wrap.
- Flush mid-frame: queue 4 bytes, assert `flush` while the 1st is in WAIT → 1st byte completes, no further `tx_en`, `level` = 0, `overflow` cleared.
- Async reset mid-frame: assert `rst` between edges during WAIT → outputs take their reset values immediately, and no `tx_en` occurs until a new write after reset release.
